// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: widths and FSM encoding shared by the partial-sum accumulator.
package psum_accumulator_pkg;
    localparam int BITS_SIP_DOT_ADDER = 16;
    localparam int BITS_ACC = 32;
    localparam int BITS_PSUM_SHIFT = 4;
    localparam int BITS_PSUM_LEN = 8;
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
endpackage

// File: rtl/psum_shift_ext.sv
// psum_shift_ext: sign-extends and shifts a PE partial sum to accumulator width.
// With PSUM_ACC_SAT_EN the shifted term is clamped and o_ovf flags lost significant bits.
module psum_shift_ext
    import psum_accumulator_pkg::*;
#(
    parameter int PSUM_W = BITS_SIP_DOT_ADDER,
    parameter int ACC_W = BITS_ACC,
    parameter int SHIFT_W = BITS_PSUM_SHIFT
) (
    input  logic [PSUM_W-1:0]  i_psum,
    input  logic [SHIFT_W-1:0] i_shift,
`ifdef PSUM_ACC_SAT_EN
    output logic               o_ovf,
`endif
    output logic [ACC_W-1:0]   o_term
);
`ifdef PSUM_ACC_SAT_EN
    localparam int EW = ACC_W + (1 << SHIFT_W);
    logic [EW-1:0] wide;
    always_comb begin
        wide = EW'(signed'(i_psum)) << i_shift;
        // Fits in ACC_W only if every bit above the sign position matches the sign.
        o_ovf = ~(&wide[EW-1:ACC_W-1]) & (|wide[EW-1:ACC_W-1]);
        o_term = o_ovf ? (wide[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                       : wide[ACC_W-1:0];
    end
`else
    always_comb o_term = ACC_W'(signed'(i_psum)) << i_shift;
`endif
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: reduces groups of shifted PE partial sums to one result on a valid/ready port.
// PSUM_ACC_SAT_EN selects saturating accumulation with a per-group sticky overflow flag.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int PSUM_W = BITS_SIP_DOT_ADDER,
    parameter int ACC_W = BITS_ACC,
    parameter int SHIFT_W = BITS_PSUM_SHIFT,
    parameter int LEN_W = BITS_PSUM_LEN
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_Valid,
    output logic               o_InReady,
    input  logic [PSUM_W-1:0]  i_PSUM,
    input  logic [SHIFT_W-1:0] i_Shift,
    input  logic [LEN_W-1:0]   i_Len,
    output logic               o_Valid,
    input  logic               i_OutReady,
    output logic [ACC_W-1:0]   o_Result,
    output logic               o_Ovf,
    output logic               o_Busy
);
    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d, term, base, sum;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
    logic valid_q, valid_d, accept, first, last;

`ifdef PSUM_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] sum_w;
    logic term_ovf, sum_ovf, grp_ovf, govf_q, govf_d, rovf_q, rovf_d;
    psum_shift_ext #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_ext (
        .i_psum(i_PSUM), .i_shift(i_Shift), .o_ovf(term_ovf), .o_term(term)
    );
`else
    psum_shift_ext #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_ext (
        .i_psum(i_PSUM), .i_shift(i_Shift), .o_term(term)
    );
`endif

    assign o_InReady = ~valid_q | i_OutReady;
    assign o_Valid = valid_q;
    assign o_Result = result_q;
    assign o_Busy = state_q == ACCUM;

    always_comb begin
        accept = i_Valid & o_InReady;
        first = state_q == IDLE;
        base = first ? '0 : acc_q;
        len_eff = first ? ((i_Len == '0) ? LEN_W'(1) : i_Len) : len_q;
        last = first ? (len_eff == LEN_W'(1)) : (cnt_q == len_q - LEN_W'(1));
`ifdef PSUM_ACC_SAT_EN
        sum_w = {base[ACC_W-1], base} + {term[ACC_W-1], term};
        sum_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        sum = sum_ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
        grp_ovf = (~first & govf_q) | term_ovf | sum_ovf;
        govf_d = govf_q;
        rovf_d = rovf_q;
`else
        sum = base + term;
`endif
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        result_d = result_q;
        valid_d = valid_q & ~i_OutReady;
        if (accept && last) begin
            result_d = sum;
            valid_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            state_d = IDLE;
`ifdef PSUM_ACC_SAT_EN
            rovf_d = grp_ovf;
            govf_d = 1'b0;
`endif
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_q + LEN_W'(1);
            len_d = len_eff;
            state_d = ACCUM;
`ifdef PSUM_ACC_SAT_EN
            govf_d = grp_ovf;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            result_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            result_q <= result_d;
            valid_q <= valid_d;
        end
    end

`ifdef PSUM_ACC_SAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            govf_q <= 1'b0;
            rovf_q <= 1'b0;
        end else begin
            govf_q <= govf_d;
            rovf_q <= rovf_d;
        end
    end
    assign o_Ovf = rovf_q;
`else
    assign o_Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed stimulus with a result scoreboard for psum_accumulator.
module tb_psum_accumulator;
    logic CLK = 1'b0, RST = 1'b1;
    logic i_Valid = 1'b0, i_OutReady = 1'b1;
    logic [15:0] i_PSUM = '0;
    logic [3:0] i_Shift = '0;
    logic [7:0] i_Len = '0;
    logic o_InReady, o_Valid, o_Ovf, o_Busy;
    logic [31:0] o_Result;
    logic v8 = 1'b0, or8 = 1'b1;
    logic [7:0] ps8 = '0, ln8 = '0;
    logic [3:0] sh8 = '0;
    logic ir8, ov8, ovf8, busy8;
    logic [7:0] res8;
    int n_pass = 0, n_total = 0, w;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;

    always #5 CLK = ~CLK;

    psum_accumulator u_dut (
        .CLK(CLK), .RST(RST), .i_Valid(i_Valid), .o_InReady(o_InReady), .i_PSUM(i_PSUM),
        .i_Shift(i_Shift), .i_Len(i_Len), .o_Valid(o_Valid), .i_OutReady(i_OutReady),
        .o_Result(o_Result), .o_Ovf(o_Ovf), .o_Busy(o_Busy)
    );

    psum_accumulator #(.PSUM_W(8), .ACC_W(8), .SHIFT_W(4), .LEN_W(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .i_Valid(v8), .o_InReady(ir8), .i_PSUM(ps8),
        .i_Shift(sh8), .i_Len(ln8), .o_Valid(ov8), .i_OutReady(or8),
        .o_Result(res8), .o_Ovf(ovf8), .o_Busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] p, input logic [3:0] s, input logic [7:0] l, output int waits);
        i_Valid = 1'b1;
        i_PSUM = p;
        i_Shift = s;
        i_Len = l;
        waits = 0;
        @(negedge CLK);
        while (!o_InReady && waits < 50) begin
            waits++;
            @(negedge CLK);
        end
        chk("inready_timeout", 32'(waits < 50), 32'd1);
        tick();
        i_Valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST && o_Valid && i_OutReady) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
            else begin
                sb_e = exp_q.pop_front();
                chk("sb_result", o_Result, sb_e);
                chk("sb_ovf", 32'(o_Ovf), 32'd0);
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_result", o_Result, 32'd0);
        chk("rst_ovf", 32'(o_Ovf), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        RST = 1'b0;
        tick();

        send(16'd3, 4'd0, 8'd4, w);
        chk("len4_busy", 32'(o_Busy), 32'd1);
        send(-16'sd1, 4'd1, 8'd0, w);
        send(16'd2, 4'd2, 8'd0, w);
        exp_q.push_back(32'd49);
        send(16'd5, 4'd3, 8'd0, w);
        chk("len4_valid", 32'(o_Valid), 32'd1);
        chk("len4_result", o_Result, 32'd49);
        chk("len4_idle", 32'(o_Busy), 32'd0);
        tick();

        exp_q.push_back(-32'sd28);
        send(-16'sd7, 4'd2, 8'd0, w);
        chk("len0_busy", 32'(o_Busy), 32'd0);
        chk("len0_result", o_Result, -32'sd28);
        exp_q.push_back(-32'sd28);
        send(-16'sd7, 4'd2, 8'd1, w);
        chk("len1_busy", 32'(o_Busy), 32'd0);
        tick();

        i_OutReady = 1'b0;
        exp_q.push_back(32'd5);
        send(16'd5, 4'd0, 8'd1, w);
        i_Valid = 1'b1;
        i_PSUM = 16'd1;
        i_Shift = 4'd0;
        i_Len = 8'd2;
        repeat (5) begin
            @(negedge CLK);
            chk("hold_inready", 32'(o_InReady), 32'd0);
            chk("hold_valid", 32'(o_Valid), 32'd1);
            chk("hold_result", o_Result, 32'd5);
            tick();
            chk("hold_no_accept", 32'(o_Busy), 32'd0);
        end
        i_OutReady = 1'b1;
        tick();
        i_Valid = 1'b0;
        chk("release_busy", 32'(o_Busy), 32'd1);
        chk("release_valid", 32'(o_Valid), 32'd0);
        exp_q.push_back(32'd3);
        send(16'd2, 4'd0, 8'd0, w);
        chk("release_result", o_Result, 32'd3);

        for (int g = 0; g < 3; g++) begin
            send(16'(g + 1), 4'd0, 8'd2, w);
            chk("b2b_first_wait", 32'(w), 32'd0);
            exp_q.push_back(32'(g + 21));
            send(16'd10, 4'd1, 8'd2, w);
            chk("b2b_last_wait", 32'(w), 32'd0);
            chk("b2b_valid", 32'(o_Valid), 32'd1);
        end
        tick();

        send(16'd100, 4'd0, 8'd4, w);
        send(16'd100, 4'd0, 8'd4, w);
        RST = 1'b1;
        tick();
        chk("midrst_valid", 32'(o_Valid), 32'd0);
        chk("midrst_result", o_Result, 32'd0);
        chk("midrst_busy", 32'(o_Busy), 32'd0);
        chk("midrst_ovf", 32'(o_Ovf), 32'd0);
        RST = 1'b0;
        tick();
        send(16'd1, 4'd0, 8'd4, w);
        send(16'd2, 4'd0, 8'd4, w);
        send(16'd3, 4'd0, 8'd4, w);
        exp_q.push_back(32'd10);
        send(16'd4, 4'd0, 8'd4, w);
        chk("postrst_result", o_Result, 32'd10);
        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        v8 = 1'b1;
        ps8 = 8'd100;
        sh8 = 4'd1;
        ln8 = 8'd2;
        tick();
        chk("w8_busy", 32'(busy8), 32'd1);
        tick();
        v8 = 1'b0;
        chk("w8_valid", 32'(ov8), 32'd1);
`ifdef PSUM_ACC_SAT_EN
        chk("w8_result", 32'(res8), 32'd127);
        chk("w8_ovf", 32'(ovf8), 32'd1);
`else
        chk("w8_result", 32'(res8), 32'h90);
        chk("w8_ovf", 32'(ovf8), 32'd0);
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
